// File: rtl/io_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_cond_pkg
//  Description : Shared constants and helpers for the pad input conditioning
//                bank (counter sizing, default debounce length, parameter
//                legality predicates).
//  Revision    : 1.0 - initial release
// ============================================================================
package io_cond_pkg;

   // 1 ms of stable input at the 126 MHz PLL clock.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 126000;

   localparam int MIN_CH          = 1;
   localparam int MAX_CH          = 32;
   localparam int MIN_SYNC_STAGES = 2;
   localparam int MAX_SYNC_STAGES = 4;

   // Counter must represent 0 .. debounce_cycles; keep at least one bit.
   function automatic int cnt_width(input int debounce_cycles);
      int w;
      w = $clog2(debounce_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit num_ch_legal(input int num_ch);
      return (num_ch >= MIN_CH) && (num_ch <= MAX_CH);
   endfunction

   function automatic bit sync_stages_legal(input int sync_stages);
      return (sync_stages >= MIN_SYNC_STAGES) && (sync_stages <= MAX_SYNC_STAGES);
   endfunction

   function automatic bit debounce_legal(input int debounce_cycles);
      return debounce_cycles >= 1;
   endfunction

endpackage : io_cond_pkg
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : One conditioning channel: optional inversion, synchroniser
//                chain, stable-count debouncer, registered rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
   import io_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit INVERT          = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic raw_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                   pin;
   logic                   s;
   logic [SYNC_STAGES-1:0] sync_d, sync_q;
   logic [CNT_W-1:0]       cnt_d, cnt_q;
   logic                   level_d, level_q;
   logic                   rise_d, rise_q;
   logic                   fall_d, fall_q;

   // Inversion is the only logic allowed ahead of the first synchroniser flop.
   assign pin = raw_in ^ INVERT;
   assign s   = sync_q[SYNC_STAGES-1];

   // Synchroniser always shifts, independent of the enable.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin};
   end

   // Debounce: clear on agreement, accept after DEBOUNCE_CYCLES mismatches.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (en) begin
         if (s == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_MAX) begin
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule : debounce_ch
`default_nettype wire

// File: rtl/pmod_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : pmod_input_conditioner
//  Description : Bank of NUM_CH independent pad conditioning channels with a
//                registered any-edge summary flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmod_input_conditioner
   import io_cond_pkg::*;
#(
   parameter int                NUM_CH          = 8,
   parameter int                SYNC_STAGES     = 2,
   parameter int                DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [NUM_CH-1:0] INVERT_MASK     = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic              any_change
);

   // Reject illegal configurations while elaborating.
   if (!num_ch_legal(NUM_CH)) begin : g_bad_num_ch
      $error("pmod_input_conditioner: NUM_CH must be 1..32");
   end
   if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
      $error("pmod_input_conditioner: SYNC_STAGES must be 2..4");
   end
   if (!debounce_legal(DEBOUNCE_CYCLES)) begin : g_bad_debounce
      $error("pmod_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INVERT          (INVERT_MASK[i])
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .en     (en),
         .raw_in (raw_in[i]),
         .level  (level[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   logic any_change_d, any_change_q;

   // Summary flag trails the per-channel pulses by one cycle.
   always_comb begin
      any_change_d = |(rise | fall);
   end

   // Summary flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         any_change_q <= 1'b0;
      end else begin
         any_change_q <= any_change_d;
      end
   end

   assign any_change = any_change_q;

endmodule : pmod_input_conditioner
`default_nettype wire
